spi_master_multi: RTL and testbench

//  Next-generation SPI master: one master engine drives NUM_SLAVES chip selects.

---
 rtl/spi_master_multi.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: one SPI engine serving NUM_SLAVES chip selects with
// per-word CPOL/CPHA, bit order, SCLK divider and CS-held bursts.
`timescale 1ns/1ps
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  cs_hold,
  input  logic [DIV_W-1:0]      clk_div,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SLAVES-1:0] cs_n
);

  localparam int TOG_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_cnt;
  logic [DIV_W-1:0]      r_h;
  logic [TOG_W-1:0]      r_tog;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsb;
  logic                  r_hold;
  logic                  r_sclk;
  logic                  r_mosi;
  logic [NUM_SLAVES-1:0] r_cs_n;

  logic             w_last;
  logic             w_accept;
  logic             w_edge;
  logic             w_lead;
  logic             w_final;
  logic             w_sample;
  logic             w_shift;
  logic [DIV_W-1:0] w_div;

  function automatic logic f_bit(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  lsb
  );
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_shl(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  lsb
  );
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_rx(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  m,
    input logic                  lsb
  );
    return lsb ? {m, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], m};
  endfunction

  // Out-of-range selects decode to no active chip select.
  function automatic logic [NUM_SLAVES-1:0] f_cs(
    input logic [SEL_W-1:0] s
  );
    logic [NUM_SLAVES-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(s) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign w_last   = (r_cnt == r_h - DIV_W'(1));
  assign tx_ready = (r_state == IDLE) |
                    ((r_state == HOLD) & w_last & r_hold);
  assign w_accept = tx_valid & tx_ready;
  assign w_div    = (clk_div == '0) ? DIV_W'(1) : clk_div;

  // Toggle k+1 is about to happen; odd toggles are leading edges.
  assign w_edge   = w_last & ((r_state == SETUP) |
                    ((r_state == XFER) & (r_tog != TOG_LAST)));
  assign w_lead   = ~r_tog[0];
  assign w_final  = (r_tog == TOG_LAST - TOG_W'(1));
  assign w_sample = w_lead ^ r_cpha;
  assign w_shift  = ~w_sample & ~w_final;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_h        <= DIV_W'(1);
      r_tog      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_hold     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_state <= SETUP;
        r_cnt   <= '0;
        r_h     <= w_div;
        r_tog   <= '0;
        r_cpol  <= cpol;
        r_cpha  <= cpha;
        r_lsb   <= lsb_first;
        r_hold  <= cs_hold;
        r_sclk  <= cpol;
        if (r_state == IDLE) r_cs_n <= f_cs(slave_sel);
        if (!cpha) begin
          r_mosi <= f_bit(tx_data, lsb_first);
          r_tx   <= f_shl(tx_data, lsb_first);
        end else begin
          r_tx   <= tx_data;
        end
      end else begin
        if (r_state != IDLE) begin
          r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
        end
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
          end
          SETUP: begin
            if (w_last) r_state <= XFER;
          end
          XFER: begin
            if (w_last && (r_tog == TOG_LAST)) begin
              r_state    <= HOLD;
              r_rx_data  <= r_rx;
              r_rx_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (w_last) begin
              r_state <= GAP;
              r_cs_n  <= '1;
            end
          end
          GAP: begin
            if (w_last) r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
        if (w_edge) begin
          r_sclk <= ~r_sclk;
          r_tog  <= r_tog + TOG_W'(1);
          if (w_sample) r_rx <= f_rx(r_rx, miso, r_lsb);
          if (w_shift) begin
            r_mosi <= f_bit(r_tx, r_lsb);
            r_tx   <= f_shl(r_tx, r_lsb);
          end
        end
      end
    end
  end

  assign busy     = (r_state != IDLE);
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign cs_n     = r_cs_n;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: vector table, hand sequences and random words
// checked against a word-level SPI timing/slave model.
`timescale 1ns/1ps
module tb_spi_master_multi;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [2:0] slave_sel;
  logic       cpol;
  logic       cpha;
  logic       lsb_first;
  logic       cs_hold;
  logic [7:0] clk_div;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [3:0] cs_n;

  spi_master_multi #(
    .DATA_WIDTH(8),
    .NUM_SLAVES(4),
    .SEL_W(3),
    .DIV_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .slave_sel(slave_sel),
    .cpol(cpol),
    .cpha(cpha),
    .lsb_first(lsb_first),
    .cs_hold(cs_hold),
    .clk_div(clk_div),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .busy(busy),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .cs_n(cs_n)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic       hold;
    logic [7:0] div;
    logic [7:0] resp;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  logic       prev_hold = 1'b0;
  int         prev_h = 0;
  logic [3:0] burst_cs = 4'hF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic bsel(input logic [7:0] w, input logic lsb,
                                input int i);
    logic [7:0] t;
    t = lsb ? (w >> i) : (w >> (7 - i));
    return t[0];
  endfunction

  function automatic logic [3:0] dec(input logic [2:0] s);
    logic [3:0] r;
    r = 4'hF;
    if (s < 3'd4) r[s[1:0]] = 1'b0;
    return r;
  endfunction

  task automatic scramble();
    tx_valid  = 1'b0;
    tx_data   = 8'($urandom);
    slave_sel = 3'($urandom);
    cpol      = 1'($urandom);
    cpha      = 1'($urandom);
    lsb_first = 1'($urandom);
    cs_hold   = 1'($urandom);
    clk_div   = 8'($urandom);
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    repeat (n) @(negedge clk);
    prev_hold = 1'b0;
    prev_h    = 0;
  endtask

  // One word: wait for ready, present it, then watch H*18 cycles.
  task automatic do_word(input vec_t v);
    int         h, n, edges, nbits, idx, nrx, rx_at;
    logic       ps, pos_ok, busy_ok, rdy_ok, gap_ok, lead;
    logic [3:0] cs_seen;
    logic [7:0] cap, rxd;
    h = (v.div == 8'd0) ? 1 : int'(v.div);
    n = 0;
    gap_ok = 1'b1;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (!tx_ready && cs_n !== 4'hF) gap_ok = 1'b0;
    end
    chk("ready_wait", 32'(tx_ready), 32'(1));
    if (!prev_hold && prev_h > 0) begin
      chk("gap_len", 32'(n), 32'(prev_h + 1));
      chk("gap_cs_high", 32'(gap_ok), 32'(1));
    end
    tx_valid  = 1'b1;
    tx_data   = v.data;
    slave_sel = v.sel;
    cpol      = v.cpol;
    cpha      = v.cpha;
    lsb_first = v.lsb;
    cs_hold   = v.hold;
    clk_div   = v.div;
    idx = 0;
    if (!v.cpha) miso = bsel(v.resp, v.lsb, 0);
    edges = 0; nbits = 0; nrx = 0; rx_at = 0;
    cap = '0; rxd = '0; ps = 1'b0;
    pos_ok = 1'b1; busy_ok = 1'b1; rdy_ok = 1'b1;
    cs_seen = v.exp_cs;
    for (int i = 1; i <= h * 18; i++) begin
      @(negedge clk);
      scramble();
      if (i == 1) begin
        chk("setup_sclk", 32'(sclk), 32'(v.cpol));
        ps = sclk;
      end else if (sclk !== ps) begin
        ps = sclk;
        edges++;
        if (i != h * edges + 1) pos_ok = 1'b0;
        lead = ((edges % 2) == 1);
        if (lead != v.cpha) begin
          if (nbits < 8) begin
            cap = v.lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
            nbits++;
          end
        end else if (v.cpha) begin
          if (idx < 8) miso = bsel(v.resp, v.lsb, idx);
          idx++;
        end else begin
          idx++;
          if (idx < 8) miso = bsel(v.resp, v.lsb, idx);
        end
      end
      if (cs_n !== v.exp_cs && cs_seen === v.exp_cs) cs_seen = cs_n;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (rx_valid === 1'b1) begin
        nrx++;
        rx_at = i;
        rxd = rx_data;
      end
      if (i < h * 18 && tx_ready !== 1'b0) rdy_ok = 1'b0;
    end
    chk("sclk_edges", 32'(edges), 32'(16));
    chk("edge_timing", 32'(pos_ok), 32'(1));
    chk("mosi_word", 32'(cap), 32'(v.data));
    chk("rx_pulses", 32'(nrx), 32'(1));
    chk("rx_cycle", 32'(rx_at), 32'(h * 17 + 1));
    chk("rx_data", 32'(rxd), 32'(v.exp_rx));
    chk("cs_n", 32'(cs_seen), 32'(v.exp_cs));
    chk("busy", 32'(busy_ok), 32'(1));
    chk("ready_early", 32'(rdy_ok), 32'(1));
    chk("ready_last", 32'(tx_ready), 32'(v.hold));
    chk("sclk_rest", 32'(sclk), 32'(v.cpol));
    prev_hold = v.hold;
    prev_h    = h;
    burst_cs  = v.exp_cs;
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   nrx_after;

  initial begin
    rst = 1'b0;
    tx_valid = 1'b0; tx_data = '0; slave_sel = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_hold = 1'b0; clk_div = '0; miso = 1'b0;

    //             data   sel  pol pha lsb hld div    resp   rx     cs
    tbl[0] = '{8'hA5, 3'd2, 0, 0, 0, 0, 8'd1, 8'h3C, 8'h3C, 4'b1011};
    tbl[1] = '{8'h81, 3'd0, 1, 1, 1, 0, 8'd3, 8'h01, 8'h01, 4'b1110};
    tbl[2] = '{8'h11, 3'd1, 0, 0, 0, 1, 8'd2, 8'h5A, 8'h5A, 4'b1101};
    tbl[3] = '{8'h22, 3'd3, 0, 1, 0, 1, 8'd2, 8'hC3, 8'hC3, 4'b1101};
    tbl[4] = '{8'h33, 3'd0, 1, 0, 1, 0, 8'd1, 8'h96, 8'h96, 4'b1101};
    tbl[5] = '{8'h6E, 3'd3, 0, 0, 0, 0, 8'd0, 8'h77, 8'h77, 4'b0111};
    tbl[6] = '{8'h6E, 3'd3, 0, 0, 0, 0, 8'd1, 8'h77, 8'h77, 4'b0111};
    tbl[7] = '{8'hC9, 3'd5, 0, 1, 0, 0, 8'd1, 8'hE4, 8'hE4, 4'b1111};

    #12;
    chk("rst_sclk", 32'(sclk), 32'(0));
    chk("rst_mosi", 32'(mosi), 32'(0));
    chk("rst_cs_n", 32'(cs_n), 32'(4'hF));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) do_word(tbl[k]);

    // Reset in the middle of bit 4 of a word.
    idle(3);
    tx_valid = 1'b1; tx_data = 8'hF0; slave_sel = 3'd1;
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
    cs_hold = 1'b0; clk_div = 8'd2;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'(1));
    chk("mid_cs_n", 32'(cs_n), 32'(4'b1101));
    #2 rst = 1'b0;
    #1;
    chk("arst_cs_n", 32'(cs_n), 32'(4'hF));
    chk("arst_sclk", 32'(sclk), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_rx_valid", 32'(rx_valid), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nrx_after = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0) nrx_after++;
    end
    chk("arst_no_rx", 32'(nrx_after), 32'(0));
    chk("arst_idle_ready", 32'(tx_ready), 32'(1));
    prev_hold = 1'b0;
    prev_h = 0;

    for (int k = 0; k < 40; k++) begin
      rv.data   = 8'($urandom);
      rv.sel    = 3'($urandom_range(0, 7));
      rv.cpol   = 1'($urandom);
      rv.cpha   = 1'($urandom);
      rv.lsb    = 1'($urandom);
      rv.hold   = 1'($urandom);
      rv.div    = 8'($urandom_range(0, 3));
      rv.resp   = 8'($urandom);
      rv.exp_rx = rv.resp;
      rv.exp_cs = prev_hold ? burst_cs : dec(rv.sel);
      do_word(rv);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 5));
    end
    idle(30);
    chk("final_cs_n", 32'(cs_n), 32'(4'hF));
    chk("final_busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
